pipe_buf_ab: RTL and testbench
==============================

PIPE_BUF_AB -- requirements
Module: pipe_buf_ab

Interface
REQ-001 Parameter WIDTH, default 9, bit width of each operand channel (A and B); legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port flush  input  1  synchronous discard of all held entries.
REQ-006 Port in_valid  input  1  upstream presents an operand pair.
REQ-007 Port in_ready  output  1  block accepts the pair this cycle.
REQ-008 Port in_a  input  WIDTH  operand A.
REQ-009 Port in_b  input  WIDTH  operand B.
REQ-010 Port out_valid  output  1  out_a/out_b hold a valid pair.
REQ-011 Port out_ready  input  1  downstream consumes the pair this cycle.
REQ-012 Port out_a  output  WIDTH  delayed operand A.
REQ-013 Port out_b  output  WIDTH  delayed operand B.
REQ-014 Port occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 The block SHALL hold DEPTH stages; each stage k (0..DEPTH-1) has registers a[k], b[k] and a valid bit v[k]. Stage 0 is the input stage. Stage DEPTH-1 drives out_a, out_b and out_valid directly from registers.
REQ-016 Transfer rule: in = in_valid && in_ready; out = out_valid && out_ready.
REQ-017 Stage DEPTH-1 SHALL load when !v[DEPTH-1] || out_ready; stage k<DEPTH-1 SHALL load when !v[k] || load[k+1] (bubble collapsing).
REQ-018 in_ready SHALL equal load[0], computed combinationally; in_ready SHALL NOT depend on in_valid.
REQ-019 When stage k loads, it takes a/b/v of stage k-1 (stage 0 takes in_a/in_b/in_valid). A stage that does not load SHALL hold its a, b and v.
REQ-020 Latency with out_ready held high: a pair accepted at edge N SHALL appear on out_a/out_b with out_valid=1 after edge N+DEPTH-1. Throughput: one pair per cycle.
REQ-021 Pairs SHALL leave in the order they were accepted; none SHALL be dropped or duplicated except by flush or rst.
REQ-022 Full: when all v[k]=1 and out_ready=0, in_ready SHALL be 0 and all state SHALL hold.
REQ-023 Full with out_ready=1: in_ready SHALL be 1, and a simultaneous in and out SHALL keep occupancy at DEPTH.
REQ-024 out_a/out_b SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 flush=1 SHALL clear all v[k] at the edge, with priority over load. A pair offered in the same cycle SHALL be discarded. in_ready SHALL still follow REQ-018 during the flush cycle. Data registers are not cleared.
REQ-026 occupancy SHALL equal the registered count of v[k]=1. It SHALL update as +1 on in-only, -1 on out-only, and unchanged on both or neither; it SHALL be 0 after flush.

Reset
REQ-027 On rst=1 at a rising edge, all v[k], all a[k]/b[k] and occupancy SHALL become 0. The outputs are therefore out_valid=0, out_a=0, out_b=0, occupancy=0, and in_ready=1 in the following cycle.
REQ-028 rst SHALL override flush and any in-flight transfer; a pair offered in the reset cycle SHALL be discarded.

Configuration
REQ-029 Macro PIPE_BUF_AB_OCCUPANCY_EN: when defined, the occupancy counter is implemented per REQ-026.
REQ-030 When PIPE_BUF_AB_OCCUPANCY_EN is undefined, occupancy SHALL be tied to 0, no counter logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-031 WIDTH=9, DEPTH=2, out_ready=1, stream in_a=0x001..0x005 and in_b=0x1FF..0x1FB back-to-back -> outputs arrive in the same order, first pair valid after edge N+1, no gaps.
REQ-032 DEPTH=3, fill with 3 pairs while out_ready=0 -> in_ready=0, occupancy=3, out_a holds first pair. Then raise out_ready for 1 cycle with in_valid=1 -> occupancy stays 3, and the next output is the second pair.
REQ-033 DEPTH=4, occupancy=2, assert flush together with in_valid=1, in_a=0x0AA -> next cycle occupancy=0, out_valid=0, and 0x0AA never appears.
REQ-034 Mid-stream rst with occupancy=2 and in_valid=1 -> next cycle all outputs 0, in_ready=1. A subsequent pair emerges after DEPTH-1 edges.
REQ-035 DEPTH=1, toggle out_ready 1,0,1,0 under continuous in_valid -> one pair delivered per out_ready=1 cycle, in order, with no loss.
REQ-036 Build without PIPE_BUF_AB_OCCUPANCY_EN and rerun REQ-032 -> same data behaviour, occupancy constant 0.

Source files
------------

// File: rtl/pipe_buf_ab.sv
// Bubble-collapsing pipeline buffer carrying an A/B operand pair through DEPTH register stages.
// Optional occupancy counter enabled by defining PIPE_BUF_AB_OCCUPANCY_EN; otherwise occupancy is tied to 0.
module pipe_buf_ab #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  // Handshake: a pair moves on an edge where valid && ready are both high on that side;
  // in_ready never looks at in_valid, and out_a/out_b hold while out_valid && !out_ready.

  logic [WIDTH-1:0] a_q [DEPTH];
  logic [WIDTH-1:0] b_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] load;
  logic             chain;

  // A stage may load if it, or any stage downstream of it, has room to move.
  always_comb begin
    chain = out_ready;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain   = chain || !v_q[k];
      load[k] = chain;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        a_q[0] <= in_a;
        b_q[0] <= in_b;
        v_q[0] <= in_valid;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
      // Flush drops every entry but leaves the data registers as they are.
      if (flush) v_q <= '0;
    end
  end

`ifdef PIPE_BUF_AB_OCCUPANCY_EN
  logic [OW-1:0] occ_q;
  logic          do_in;
  logic          do_out;

  assign do_in  = in_valid && in_ready;
  assign do_out = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (do_in && !do_out) begin
      occ_q <= occ_q + OW'(1);
    end else if (do_out && !do_in) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign occupancy = occ_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_pipe_buf_ab.sv
// Bench for pipe_buf_ab: four instances (DEPTH 1..4, WIDTH 9) share one stimulus stream and are
// each checked every cycle against a queue-of-pairs model, plus directed literal expectations.
module tb_pipe_buf_ab;

  localparam int NI = 4;
  localparam int W  = 9;
`ifdef PIPE_BUF_AB_OCCUPANCY_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           pos;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [W-1:0] out_a_w     [NI];
  logic [W-1:0] out_b_w     [NI];
  logic [2:0]   occ_w       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = g + 1;
    logic [$clog2(D+1)-1:0] occ_l;
    pipe_buf_ab #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_a     (out_a_w[g]),
      .out_b     (out_b_w[g]),
      .occupancy (occ_l)
    );
    assign occ_w[g] = 3'(occ_l);
  end

  // ---------------- scoreboard ----------------
  ent_t exp_q [NI][$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d (depth %0d) t=%0t: got %0h expected %0h", name, inst, inst + 1, $time, act, exp);
    end
  endtask

  // Pairs flow in order; each entry remembers its stage. An entry moves up one stage when
  // out_ready is high or when some slot above it is free; the buffer refuses input only when
  // it holds DEPTH pairs and out_ready is low.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int   d;
      bit   rdy;
      bit   take;
      ent_t e;
      d    = i + 1;
      rdy  = (exp_q[i].size() < d) || out_ready;
      take = in_valid && rdy;
      if (rst || flush) begin
        exp_q[i].delete();
      end else begin
        if (out_ready && exp_q[i].size() > 0 && exp_q[i][0].pos == d - 1)
          e = exp_q[i].pop_front();
        for (int j = 0; j < exp_q[i].size(); j++) begin
          if (out_ready || ((d - 1 - exp_q[i][j].pos) - j) > 0)
            exp_q[i][j].pos = exp_q[i][j].pos + 1;
        end
        if (take) begin
          e.a   = in_a;
          e.b   = in_b;
          e.pos = 0;
          exp_q[i].push_back(e);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare, after the driver has set this cycle's inputs.
  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        bit exp_v;
        exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].pos == i);
        chk("in_ready", i, 64'(in_ready_w[i]), 64'((exp_q[i].size() < i + 1) || out_ready));
        chk("out_valid", i, 64'(out_valid_w[i]), 64'(exp_v));
        if (exp_v) begin
          chk("out_a", i, 64'(out_a_w[i]), 64'(exp_q[i][0].a));
          chk("out_b", i, 64'(out_b_w[i]), 64'(exp_q[i][0].b));
        end
        chk("occupancy", i, 64'(occ_w[i]), OCC_EN ? 64'(exp_q[i].size()) : 64'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit ordy, input bit fl, input bit r);
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_out_valid"}, i, 64'(out_valid_w[i]), 64'(0));
      chk({tag, "_out_a"}, i, 64'(out_a_w[i]), 64'(0));
      chk({tag, "_out_b"}, i, 64'(out_b_w[i]), 64'(0));
      chk({tag, "_in_ready"}, i, 64'(in_ready_w[i]), 64'(1));
      chk({tag, "_occ"}, i, 64'(occ_w[i]), 64'(0));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    idle(1'b0);
    chk_en = 1'b1;
    #2;
    chk_cleared("reset");

    // Back-to-back stream, out_ready high; depth-2 output lags acceptance by one edge.
    for (int k = 0; k < 7; k++) begin
      cyc(k < 5, W'(k + 1), W'(9'h1FF - k), 1'b1, 1'b0, 1'b0);
      #2;
      if (k == 1) chk("stream_first_gap", 1, 64'(out_valid_w[1]), 64'(0));
      if (k >= 2) begin
        chk("stream_valid", 1, 64'(out_valid_w[1]), 64'(1));
        chk("stream_a", 1, 64'(out_a_w[1]), 64'(k - 1));
        chk("stream_b", 1, 64'(out_b_w[1]), 64'(9'h1FF - (k - 2)));
      end
    end
    repeat (3) idle(1'b1);

    // Fill depth 3 with out_ready low, then one simultaneous in/out cycle.
    for (int k = 0; k < 3; k++) cyc(1'b1, W'(9'h010 + k), W'(9'h110 + k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h013, 9'h113, 1'b0, 1'b0, 1'b0);
    #2;
    chk("full_in_ready", 2, 64'(in_ready_w[2]), 64'(0));
    chk("full_out_a", 2, 64'(out_a_w[2]), 64'(9'h010));
    chk("full_occ", 2, 64'(occ_w[2]), OCC_EN ? 64'(3) : 64'(0));
    cyc(1'b1, 9'h013, 9'h113, 1'b1, 1'b0, 1'b0);
    #2;
    chk("full_ordy_in_ready", 2, 64'(in_ready_w[2]), 64'(1));
    idle(1'b0);
    #2;
    chk("swap_occ", 2, 64'(occ_w[2]), OCC_EN ? 64'(3) : 64'(0));
    chk("swap_valid", 2, 64'(out_valid_w[2]), 64'(1));
    chk("swap_out_a", 2, 64'(out_a_w[2]), 64'(9'h011));
    chk("swap_out_b", 2, 64'(out_b_w[2]), 64'(9'h111));
    repeat (6) idle(1'b1);

    // Flush with a pair offered in the same cycle; 0x0AA must never appear.
    cyc(1'b1, 9'h020, 9'h120, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h021, 9'h121, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h0AA, 9'h0AA, 1'b0, 1'b1, 1'b0);
    #2;
    chk("flush_in_ready", 3, 64'(in_ready_w[3]), 64'(1));
    chk("flush_pre_occ", 3, 64'(occ_w[3]), OCC_EN ? 64'(2) : 64'(0));
    idle(1'b1);
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("flush_occ", i, 64'(occ_w[i]), 64'(0));
      chk("flush_valid", i, 64'(out_valid_w[i]), 64'(0));
    end
    repeat (6) idle(1'b1);
    chk("flush_no_aa", 3, 64'(out_valid_w[3]), 64'(0));

    // Mid-stream reset with a pair offered, then latency of a fresh pair through depth 4.
    cyc(1'b1, 9'h030, 9'h130, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h031, 9'h131, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h055, 9'h155, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    #2;
    chk_cleared("midrst");
    cyc(1'b1, 9'h077, 9'h177, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      idle(1'b1);
      #2;
      chk("rst_latency_valid", 3, 64'(out_valid_w[3]), 64'(t == 4));
      if (t == 4) chk("rst_latency_a", 3, 64'(out_a_w[3]), 64'(9'h077));
    end
    repeat (4) idle(1'b1);

    // Depth 1 with out_ready toggling under continuous input.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, W'(9'h040 + k), W'(9'h140 + k), (k % 2) == 0, 1'b0, 1'b0);
      #2;
      if ((k % 2) == 1) begin
        chk("toggle_valid", 0, 64'(out_valid_w[0]), 64'(1));
        chk("toggle_a", 0, 64'(out_a_w[0]), 64'(9'h040 + k - 1));
      end
    end
    repeat (5) idle(1'b1);

    // Random traffic with occasional flush and reset.
    repeat (3000) begin
      cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end
    repeat (8) idle(1'b1);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
